// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder; the only adding element in the serial datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one result bit per RUN cycle through a single full adder,
// with the result published only when the addition completes.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shift;

  fulladder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Partial result with this cycle's bit entering at the MSB; bit 0 only matters on the last cycle.
  assign res_shift = {fa_sum, res};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          res   <= res_shift[WIDTH-1:1];
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            sum   <= res_shift;
            cout  <= fa_cout;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter SHALL be: WIDTH, 8, operand width in bits (valid range 2..32).
REQ-002 Port SHALL be: clk  input  1  sole clock; all logic updates on its rising edge.
REQ-003 Port SHALL be: rst  input  1  reset; synchronous, active-high.
REQ-004 Port SHALL be: start  input  1  request to begin an addition; accepted only while ready=1.
REQ-005 Port SHALL be: a  input  WIDTH  operand A; sampled only on the accepting edge.
REQ-006 Port SHALL be: b  input  WIDTH  operand B; sampled only on the accepting edge.
REQ-007 Port SHALL be: cin  input  1  carry-in; sampled only on the accepting edge.
REQ-008 Port SHALL be: ready  output  1  block can accept start.
REQ-009 Port SHALL be: busy  output  1  addition in progress.
REQ-010 Port SHALL be: done  output  1  one-cycle pulse marking a valid result.
REQ-011 Port SHALL be: sum  output  WIDTH  result bits.
REQ-012 Port SHALL be: cout  output  1  final carry-out.

Function
REQ-013 FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE SHALL drive ready=1, busy=0 and done=0.
REQ-015 In IDLE, start=1 SHALL load a, b and cin into internal shift/carry registers, clear the bit counter and enter RUN.
REQ-016 RUN SHALL drive ready=0, busy=1 and done=0.
REQ-017 Each RUN cycle SHALL feed the LSBs of the A/B shift registers and the carry register through one full-adder instance.
REQ-018 Each RUN cycle SHALL shift the sum bit into the result MSB, shift A/B right, store the carry-out, and increment the counter.
REQ-019 RUN SHALL last exactly WIDTH cycles; on the edge completing bit WIDTH-1 the FSM SHALL enter DONE.
REQ-020 DONE SHALL drive done=1, busy=0 and ready=1 for exactly one cycle, then return to IDLE unless start=1.
REQ-021 Latency: start accepted in cycle 0 SHALL give RUN in cycles 1..WIDTH and done=1 in cycle WIDTH+1.
REQ-022 sum and cout SHALL equal the WIDTH+1-bit result of a + b + cin, truncated to WIDTH bits plus carry, whenever done=1.
REQ-023 sum and cout SHALL hold their values from DONE until the next accepted start.
REQ-024 sum and cout SHALL NOT change while busy=1; partial results are held in internal registers only.
REQ-025 start=1 during RUN SHALL be ignored with no effect on state, operands or outputs.
REQ-026 start=1 during DONE SHALL be accepted: fresh operands load and the FSM enters RUN next cycle, giving back-to-back operation with done pulsed once per addition.
REQ-027 Unused FSM encodings SHALL recover to IDLE on the next edge.

Reset
REQ-028 rst=1 on a clock edge SHALL force IDLE and set ready=1, busy=0, done=0, sum=0, cout=0, and clear the counter, shift and carry registers.
REQ-029 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL occur for the aborted addition.
REQ-030 rst SHALL take priority over start on the same edge.

Structure
REQ-031 Shared package serial_adder_pkg SHALL hold the state type (IDLE/RUN/DONE encodings) and the default WIDTH constant.
REQ-032 The datapath SHALL instantiate exactly one existing fulladder sub-module (ports a, b, cin, sum, cout); no other adder logic is permitted.
REQ-033 The counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=8)
REQ-034 a=8'h00, b=8'h00, cin=0, start pulse in cycle 0 -> done=1 in cycle 9 only, sum=8'h00, cout=0.
REQ-035 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 at done; values held for 5 idle cycles afterwards.
REQ-036 a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0.
REQ-037 Accept a=8'h10, b=8'h20, then hold start=1 with a=8'hFF during cycles 2..8 -> ignored; done in cycle 9 with sum=8'h30, cout=0.
REQ-038 rst=1 in cycle 4 of RUN -> next cycle busy=0, ready=1, sum=0, cout=0, and done stays 0 for 12 cycles.
REQ-039 start held in the DONE cycle with a=8'h01, b=8'h01 -> second done exactly 9 cycles after the first, with sum=8'h02.
